// File: rtl/demux_1_to_4_stream_if.sv
// ============================================================================
// Module      : demux_1_to_4_stream_if
// Description : Signal bundle for the 1-to-4 stream demultiplexer. The single
//               upstream stream, the four downstream channels and the busy
//               flag are carried together. The slave modport is the
//               demultiplexer's view; the master modport is the view of the
//               logic that surrounds it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface demux_1_to_4_stream_if #(
  parameter int DATA_WIDTH = 8
);
  // Upstream stream
  logic [1:0]            i_Select;
  logic                  i_Valid;
  logic [DATA_WIDTH-1:0] i_Data;
  logic                  i_Last;
  logic                  o_Ready;
  // Downstream channels
  logic [3:0]            o_Valid;
  logic [DATA_WIDTH-1:0] o_Data1;
  logic [DATA_WIDTH-1:0] o_Data2;
  logic [DATA_WIDTH-1:0] o_Data3;
  logic [DATA_WIDTH-1:0] o_Data4;
  logic [3:0]            o_Last;
  logic [3:0]            i_Ready;
  // Status
  logic                  o_Busy;

  modport slave (
    input  i_Select, i_Valid, i_Data, i_Last, i_Ready,
    output o_Ready, o_Valid, o_Data1, o_Data2, o_Data3, o_Data4, o_Last, o_Busy
  );

  modport master (
    output i_Select, i_Valid, i_Data, i_Last, i_Ready,
    input  o_Ready, o_Valid, o_Data1, o_Data2, o_Data3, o_Data4, o_Last, o_Busy
  );
endinterface

`default_nettype wire

// File: rtl/demux_1_to_4_stream.sv
// ============================================================================
// Module      : demux_1_to_4_stream
// Description : Routes one valid/ready stream to one of four channels. The
//               destination is captured on the first beat of a packet and
//               held until the last beat is accepted. Every channel owns a
//               one-entry output register, so a stalled channel never blocks
//               data already buffered in the others.
//               Optional feature macro: DEMUX_ROUND_ROBIN_EN - when defined,
//               i_Select is ignored and packets rotate over channels 0..3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_1_to_4_stream #(
  parameter int DATA_WIDTH = 8
) (
  input  wire logic              i_Clk,
  input  wire logic              i_Rst_L,
  demux_1_to_4_stream_if.slave   bus
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic [0:0]            r_State;
  logic [0:0]            w_NextState;
  logic [1:0]            r_Sel;
  logic [1:0]            w_Sel;
  logic                  w_Ready;
  logic                  w_Accept;
  logic [3:0]            r_Valid;
  logic [3:0]            r_Last;
  logic [DATA_WIDTH-1:0] r_Data [4];

`ifdef DEMUX_ROUND_ROBIN_EN
  logic [1:0] r_Ptr;
  logic       w_unused_select;

  // Destination is ignored in rotation mode; fold it away explicitly.
  assign w_unused_select = ^bus.i_Select;

  // Rotation pointer moves on to the next channel whenever a packet closes.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Ptr <= 2'd0;
    end else if (w_Accept && bus.i_Last) begin
      r_Ptr <= r_Ptr + 2'd1;
    end
  end
`endif

  // Effective destination: the locked channel while a packet is open.
  always_comb begin
    w_Sel = r_Sel;
    if (r_State != S_LOCKED) begin
`ifdef DEMUX_ROUND_ROBIN_EN
      w_Sel = r_Ptr;
`else
      w_Sel = bus.i_Select;
`endif
    end
  end

  // A beat fits when the target stage is empty or drains on this edge.
  assign w_Ready     = !r_Valid[w_Sel] || bus.i_Ready[w_Sel];
  assign w_Accept    = bus.i_Valid && w_Ready;
  assign bus.o_Ready = w_Ready;

  // State register; the destination is captured only when a multi-beat packet opens.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State <= S_IDLE;
      r_Sel   <= 2'd0;
    end else begin
      r_State <= w_NextState;
      if (r_State == S_IDLE && w_Accept && !bus.i_Last) begin
        r_Sel <= w_Sel;
      end
    end
  end

  // Next state: open on a non-last accepted beat, close on an accepted last beat.
  always_comb begin
    w_NextState = r_State;
    case (r_State)
      S_IDLE:   if (w_Accept && !bus.i_Last) w_NextState = S_LOCKED;
      S_LOCKED: if (w_Accept &&  bus.i_Last) w_NextState = S_IDLE;
      default:  w_NextState = S_IDLE;
    endcase
  end

  // FSM output: busy while a packet is open.
  always_comb begin
    bus.o_Busy = 1'b0;
    if (r_State == S_LOCKED) bus.o_Busy = 1'b1;
  end

  generate
    for (genvar n = 0; n < 4; n++) begin : g_channel
      logic w_Load;
      assign w_Load = w_Accept && (w_Sel == 2'(n));

      // Channel stage: a reload wins over a drain; payload holds while empty.
      always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
          r_Valid[n] <= 1'b0;
          r_Last[n]  <= 1'b0;
          r_Data[n]  <= '0;
        end else if (w_Load) begin
          r_Valid[n] <= 1'b1;
          r_Last[n]  <= bus.i_Last;
          r_Data[n]  <= bus.i_Data;
        end else if (r_Valid[n] && bus.i_Ready[n]) begin
          r_Valid[n] <= 1'b0;
        end
      end
    end
  endgenerate

  assign bus.o_Valid = r_Valid;
  assign bus.o_Last  = r_Last;
  assign bus.o_Data1 = r_Data[0];
  assign bus.o_Data2 = r_Data[1];
  assign bus.o_Data3 = r_Data[2];
  assign bus.o_Data4 = r_Data[3];

endmodule

`default_nettype wire

// File: tb/tb_demux_1_to_4_stream.sv
// ============================================================================
// Module      : tb_demux_1_to_4_stream
// Description : Self-checking bench for demux_1_to_4_stream. A packet-level
//               model tracks what each channel must hold; a compare process
//               checks every falling edge, and directed vectors pin literals.
//               Follows DEMUX_ROUND_ROBIN_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_1_to_4_stream;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic chk_en = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  demux_1_to_4_stream_if #(.DATA_WIDTH(8)) bus ();

  demux_1_to_4_stream #(.DATA_WIDTH(8)) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- packet-level reference model ----------------
  bit         m_full [4];
  logic [7:0] m_data [4];
  bit         m_last [4];
  bit         m_open = 0;
  int         m_dest = 0;
  int         m_ptr  = 0;

  function automatic int target();
    if (m_open) return m_dest;
`ifdef DEMUX_ROUND_ROBIN_EN
    return m_ptr;
`else
    return int'(bus.i_Select);
`endif
  endfunction

  function automatic bit model_ready();
    int d = target();
    return !m_full[d] || bus.i_Ready[d];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 4; n++) begin
        m_full[n] = 0; m_data[n] = 8'h00; m_last[n] = 0;
      end
      m_open = 0; m_dest = 0; m_ptr = 0;
    end else begin
      int d;
      bit take;
      d    = target();
      take = bus.i_Valid && model_ready();
      for (int n = 0; n < 4; n++)
        if (m_full[n] && bus.i_Ready[n]) m_full[n] = 0;
      if (take) begin
        m_full[d] = 1; m_data[d] = bus.i_Data; m_last[d] = bus.i_Last;
        if (bus.i_Last) begin
          m_open = 0;
          m_ptr  = (m_ptr + 1) % 4;
        end else if (!m_open) begin
          m_open = 1;
          m_dest = d;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      logic [7:0] dout [4];
      dout[0] = bus.o_Data1; dout[1] = bus.o_Data2;
      dout[2] = bus.o_Data3; dout[3] = bus.o_Data4;
      for (int n = 0; n < 4; n++) begin
        chk($sformatf("cmp_valid%0d", n), 32'(bus.o_Valid[n]), 32'(m_full[n]));
        chk($sformatf("cmp_data%0d", n),  32'(dout[n]),        32'(m_data[n]));
        chk($sformatf("cmp_last%0d", n),  32'(bus.o_Last[n]),  32'(m_last[n]));
      end
      chk("cmp_busy",  32'(bus.o_Busy),  32'(m_open));
      chk("cmp_ready", 32'(bus.o_Ready), 32'(model_ready()));
    end
  end

  // One clock: the edge that samples the current inputs, then the falling
  // edge, returning a little after it so new inputs settle before the next edge.
  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic beat(input logic [1:0] sel, input logic [7:0] d, input logic last);
    bus.i_Select = sel; bus.i_Data = d; bus.i_Last = last; bus.i_Valid = 1'b1;
  endtask

  initial begin
    bus.i_Select = 2'd2; bus.i_Valid = 1'b0; bus.i_Data = 8'hFF;
    bus.i_Last = 1'b0;   bus.i_Ready = 4'b0000;

    // Reset held while a beat is offered
    #1 rst_n = 1'b0;
    bus.i_Valid = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    #1;
    chk("rst_valid", 32'(bus.o_Valid), 32'h0);
    chk("rst_busy",  32'(bus.o_Busy),  32'h0);
    chk("rst_data",  32'({bus.o_Data1, bus.o_Data2, bus.o_Data3, bus.o_Data4}), 32'h0);
    #1;
    bus.i_Valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 32'(bus.o_Ready), 32'h1);

`ifndef DEMUX_ROUND_ROBIN_EN
    // Single-beat packet to channel 2
    beat(2'd2, 8'hA5, 1'b1);
    cyc();
    bus.i_Valid = 1'b0;
    chk("single_valid", 32'(bus.o_Valid), 32'h4);
    chk("single_data3", 32'(bus.o_Data3), 32'hA5);
    chk("single_last2", 32'(bus.o_Last[2]), 32'h1);
    chk("single_busy",  32'(bus.o_Busy), 32'h0);
    bus.i_Ready = 4'hF;
    cyc();
    chk("single_drain", 32'(bus.o_Valid), 32'h0);

    // Three-beat packet locked to channel 1, select moved mid-packet
    beat(2'd1, 8'h10, 1'b0);
    cyc();
    chk("lock_b1_data", 32'(bus.o_Data2), 32'h10);
    chk("lock_b1_busy", 32'(bus.o_Busy), 32'h1);
    beat(2'd3, 8'h11, 1'b0);
    cyc();
    chk("lock_b2_data", 32'(bus.o_Data2), 32'h11);
    chk("lock_b2_busy", 32'(bus.o_Busy), 32'h1);
    chk("lock_b2_ch3",  32'(bus.o_Valid[3]), 32'h0);
    beat(2'd3, 8'h12, 1'b1);
    cyc();
    bus.i_Valid = 1'b0;
    chk("lock_b3_data", 32'(bus.o_Data2), 32'h12);
    chk("lock_b3_last", 32'(bus.o_Last[1]), 32'h1);
    chk("lock_b3_busy", 32'(bus.o_Busy), 32'h0);
    chk("lock_b3_ch3",  32'(bus.o_Valid[3]), 32'h0);
    cyc();

    // Channel 0 stalled holding 8'h01
    bus.i_Ready = 4'b0000;
    beat(2'd0, 8'h01, 1'b1);
    cyc();
    bus.i_Valid = 1'b0;
    chk("bp_hold_valid", 32'(bus.o_Valid), 32'h1);
    chk("bp_hold_data",  32'(bus.o_Data1), 32'h01);

    // Channel 3 passes through while channel 0 stays stalled
    bus.i_Ready = 4'b1000;
    beat(2'd3, 8'h33, 1'b1);
    cyc();
    bus.i_Valid = 1'b0;
    chk("ind_valid", 32'(bus.o_Valid), 32'h9);
    chk("ind_data4", 32'(bus.o_Data4), 32'h33);
    cyc();
    chk("ind_drain", 32'(bus.o_Valid), 32'h1);
    chk("ind_data1", 32'(bus.o_Data1), 32'h01);

    // Second beat for the stalled channel is refused, then drain+reload together
    bus.i_Ready = 4'b0000;
    beat(2'd0, 8'h02, 1'b1);
    #1;
    chk("bp_ready_low", 32'(bus.o_Ready), 32'h0);
    cyc();
    chk("bp_still_01", 32'(bus.o_Data1), 32'h01);
    bus.i_Ready = 4'b0001;
    #1;
    chk("bp_ready_high", 32'(bus.o_Ready), 32'h1);
    cyc();
    bus.i_Valid = 1'b0;
    chk("bp_reload_valid", 32'(bus.o_Valid[0]), 32'h1);
    chk("bp_reload_data",  32'(bus.o_Data1), 32'h02);
    cyc();
    chk("bp_empty", 32'(bus.o_Valid), 32'h0);

    // Reset after beat 2 of a 4-beat packet
    bus.i_Ready = 4'hF;
    beat(2'd2, 8'h20, 1'b0);
    cyc();
    beat(2'd2, 8'h21, 1'b0);
    cyc();
    chk("mid_busy_before", 32'(bus.o_Busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.o_Valid), 32'h0);
    chk("mid_rst_busy",  32'(bus.o_Busy), 32'h0);
    bus.i_Valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    bus.i_Ready = 4'b0000;
    beat(2'd1, 8'h55, 1'b1);
    cyc();
    bus.i_Valid = 1'b0;
    chk("mid_new_valid", 32'(bus.o_Valid), 32'h2);
    chk("mid_new_data2", 32'(bus.o_Data2), 32'h55);
    bus.i_Ready = 4'hF;
    cyc();
`else
    // Rotation: select fixed at 3, packets land on 0,1,2,3,0
    begin
      logic [3:0] exp_onehot [5];
      exp_onehot[0] = 4'h1; exp_onehot[1] = 4'h2; exp_onehot[2] = 4'h4;
      exp_onehot[3] = 4'h8; exp_onehot[4] = 4'h1;
      bus.i_Ready = 4'hF;
      for (int k = 0; k < 5; k++) begin
        beat(2'd3, 8'h40 + 8'(k), 1'b1);
        cyc();
        chk($sformatf("rr_pkt%0d", k), 32'(bus.o_Valid), 32'(exp_onehot[k]));
      end
      bus.i_Valid = 1'b0;
      cyc();
      chk("rr_drain", 32'(bus.o_Valid), 32'h0);
    end
`endif

    cyc();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
